// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer (rst_seq).
package rst_seq_pkg;

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_FAULT
    } rst_seq_state_e;

    // Width of a counter that can reach the largest of the three cycle limits.
    function automatic int cnt_width(input int hold, input int gap, input int timeout);
        int m;
        m = hold;
        if (gap > m) m = gap;
        if (timeout > m) m = timeout;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Saturating cycle counter with synchronous clear and a terminal flag.
// tc is high on the edge that would be the term-th counted edge since clear.
module rst_seq_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    // Count enabled edges, hold at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = ({1'b0, cnt} + (CNT_W + 1)'(1)) >= {1'b0, term};

endmodule

// File: rtl/rst_seq.sv
// Staged reset sequencer: releases NUM_STAGES resets in order, each waiting on
// the previous stage's ready, with a sticky fault on ready timeout.
// Optional feature macro: RST_SEQ_SOFT_RST_EN (adds soft_rst_req re-run input).
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES     = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_STAGES-1:0]           stage_rdy,
`ifdef RST_SEQ_SOFT_RST_EN
    input  logic                            soft_rst_req,
`endif
    output logic [NUM_STAGES-1:0]           rst_out,
    output logic [$clog2(NUM_STAGES+1)-1:0] cur_stage,
    output logic                            done,
    output logic                            fault
);

    localparam int IDX_W = $clog2(NUM_STAGES + 1);
    localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);

    rst_seq_state_e        state;
    logic                  soft_req;
    logic                  rdy_cur;
    logic                  is_last;
    logic [IDX_W-1:0]      next_stage;
    logic [NUM_STAGES-1:0] rel_mask;
    logic                  tmr_clr;
    logic                  tmr_en;
    logic                  tmr_tc;
    logic [CNT_W-1:0]      tmr_term;

`ifdef RST_SEQ_SOFT_RST_EN
    assign soft_req = soft_rst_req;
`else
    assign soft_req = 1'b0;
`endif

    assign is_last    = (cur_stage == IDX_W'(NUM_STAGES - 1));
    assign next_stage = cur_stage + IDX_W'(1);

    // Select the ready of the stage being waited on and the one-hot release mask of the next stage.
    always_comb begin
        rdy_cur  = 1'b0;
        rel_mask = '0;
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            if (IDX_W'(k) == cur_stage)  rdy_cur     = stage_rdy[k];
            if (IDX_W'(k) == next_stage) rel_mask[k] = 1'b1;
        end
    end

    // Terminal count for the shared timer depends only on the phase being timed.
    always_comb begin
        tmr_term = CNT_W'(HOLD_CYCLES);
        case (state)
            S_WAIT:  tmr_term = CNT_W'(TIMEOUT_CYCLES);
            S_GAP:   tmr_term = CNT_W'(GAP_CYCLES);
            default: tmr_term = CNT_W'(HOLD_CYCLES);
        endcase
    end

    // Timer clears on every phase entry and counts while a phase is in progress.
    always_comb begin
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        if (soft_req) begin
            tmr_clr = 1'b1;
        end else begin
            case (state)
                S_HOLD: begin
                    tmr_clr = tmr_tc;
                    tmr_en  = !tmr_tc;
                end
                S_WAIT: begin
                    tmr_clr = rdy_cur;
                    tmr_en  = !rdy_cur;
                end
                S_GAP: begin
                    tmr_clr = tmr_tc;
                    tmr_en  = !tmr_tc;
                end
                default: begin
                    tmr_clr = 1'b0;
                    tmr_en  = 1'b0;
                end
            endcase
        end
    end

    rst_seq_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .term (tmr_term),
        .tc   (tmr_tc)
    );

    // Sequencer FSM with registered reset outputs, stage index and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_HOLD;
            rst_out   <= '1;
            cur_stage <= '0;
            done      <= 1'b0;
            fault     <= 1'b0;
        end else if (soft_req) begin
            state     <= S_HOLD;
            rst_out   <= '1;
            cur_stage <= '0;
            done      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (tmr_tc) begin
                        rst_out[0] <= 1'b0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Ready takes priority over a timeout landing on the same edge.
                    if (rdy_cur) begin
                        if (is_last) begin
                            done      <= 1'b1;
                            cur_stage <= IDX_W'(NUM_STAGES);
                            state     <= S_DONE;
                        end else if (GAP_CYCLES == 0) begin
                            rst_out   <= rst_out & ~rel_mask;
                            cur_stage <= next_stage;
                            state     <= S_WAIT;
                        end else begin
                            state <= S_GAP;
                        end
                    end else if (tmr_tc) begin
                        fault   <= 1'b1;
                        rst_out <= '1;
                        done    <= 1'b0;
                        state   <= S_FAULT;
                    end
                end
                S_GAP: begin
                    if (tmr_tc) begin
                        rst_out   <= rst_out & ~rel_mask;
                        cur_stage <= next_stage;
                        state     <= S_WAIT;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq.sv
`timescale 1ns/1ps
module tb_rst_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rdy_a, rdy_b, rdy_c;
    logic [3:0] ro_a, ro_b, ro_c;
    logic [2:0] cs_a, cs_b, cs_c;
    logic       dn_a, dn_b, dn_c;
    logic       ft_a, ft_b, ft_c;
`ifdef RST_SEQ_SOFT_RST_EN
    logic       soft_c;
`endif

    int errors = 0;
    int checks = 0;
    int n = 0;
    int fall_e [4];

    always #5 clk = ~clk;

    rst_seq #(.NUM_STAGES(4), .HOLD_CYCLES(16), .GAP_CYCLES(8), .TIMEOUT_CYCLES(65535)) u_a (
        .clk(clk), .rst(rst), .stage_rdy(rdy_a),
`ifdef RST_SEQ_SOFT_RST_EN
        .soft_rst_req(1'b0),
`endif
        .rst_out(ro_a), .cur_stage(cs_a), .done(dn_a), .fault(ft_a));

    rst_seq #(.NUM_STAGES(4), .HOLD_CYCLES(16), .GAP_CYCLES(0), .TIMEOUT_CYCLES(65535)) u_b (
        .clk(clk), .rst(rst), .stage_rdy(rdy_b),
`ifdef RST_SEQ_SOFT_RST_EN
        .soft_rst_req(1'b0),
`endif
        .rst_out(ro_b), .cur_stage(cs_b), .done(dn_b), .fault(ft_b));

    rst_seq #(.NUM_STAGES(4), .HOLD_CYCLES(16), .GAP_CYCLES(8), .TIMEOUT_CYCLES(100)) u_c (
        .clk(clk), .rst(rst), .stage_rdy(rdy_c),
`ifdef RST_SEQ_SOFT_RST_EN
        .soft_rst_req(soft_c),
`endif
        .rst_out(ro_c), .cur_stage(cs_c), .done(dn_c), .fault(ft_c));

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic clear_falls();
        for (int i = 0; i < 4; i++) fall_e[i] = -1;
    endtask

    // Remember the first edge at which each reset output was seen released.
    task automatic record(input logic [3:0] ro);
        for (int i = 0; i < 4; i++)
            if (!ro[i] && fall_e[i] < 0) fall_e[i] = n;
    endtask

    // Stage ready rises so that it is seen 5 edges after its reset was released.
    function automatic logic [3:0] resp(input logic [3:0] en);
        logic [3:0] r;
        for (int i = 0; i < 4; i++)
            r[i] = en[i] && (fall_e[i] >= 0) && (n >= fall_e[i] + 4);
        return r;
    endfunction

    task automatic do_reset();
        rst   = 1'b1;
        rdy_a = 4'h0;
        rdy_c = 4'h0;
        clear_falls();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n   = 0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        rdy_a = 4'h0;
        rdy_c = 4'h0;
        #1;
        checks++;
        if ({ro_a, cs_a, dn_a, ft_a} !== {4'hF, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_a: got ro=%b cs=%0d dn=%b ft=%b, want ro=1111 cs=0 dn=0 ft=0", ro_a, cs_a, dn_a, ft_a);
        end
        checks++;
        if ({ro_b, cs_b, dn_b, ft_b} !== {4'hF, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_b: got ro=%b cs=%0d dn=%b ft=%b, want ro=1111 cs=0 dn=0 ft=0", ro_b, cs_b, dn_b, ft_b);
        end
        checks++;
        if ({ro_c, cs_c, dn_c, ft_c} !== {4'hF, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_c: got ro=%b cs=%0d dn=%b ft=%b, want ro=1111 cs=0 dn=0 ft=0", ro_c, cs_c, dn_c, ft_c);
        end
    endtask

    // Runs instance A from rst fall and checks the staged release times.
    task automatic run_staged(input string tag);
        int done_e;
        int exp_fall [4];
        done_e = -1;
        exp_fall = '{16, 29, 42, 55};
        while (n < 80) begin
            tick();
            record(ro_a);
            if (dn_a && done_e < 0) done_e = n;
            rdy_a = resp(4'hF);
            if (n == 25) begin
                checks++;
                if ({ro_a, cs_a} !== {4'b1110, 3'd0}) begin
                    errors++;
                    $display("FAIL %s_gap0: got ro=%b cs=%0d, want ro=1110 cs=0", tag, ro_a, cs_a);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (fall_e[i] !== exp_fall[i]) begin
                errors++;
                $display("FAIL %s_rel%0d: released at edge %0d, want %0d", tag, i, fall_e[i], exp_fall[i]);
            end
        end
        checks++;
        if (done_e !== 60 || cs_a !== 3'd4 || ft_a !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: done edge %0d cs=%0d ft=%b, want edge 60 cs=4 ft=0", tag, done_e, cs_a, ft_a);
        end
    endtask

    task automatic test_staged();
        do_reset();
        run_staged("staged");
    endtask

    task automatic test_gap0();
        int done_e;
        done_e = -1;
        do_reset();
        while (n < 30) begin
            tick();
            record(ro_b);
            if (dn_b && done_e < 0) done_e = n;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (fall_e[i] !== 16 + i) begin
                errors++;
                $display("FAIL gap0_rel%0d: released at edge %0d, want %0d", i, fall_e[i], 16 + i);
            end
        end
        checks++;
        if (done_e !== 20 || cs_b !== 3'd4 || ft_b !== 1'b0) begin
            errors++;
            $display("FAIL gap0_done: done edge %0d cs=%0d ft=%b, want edge 20 cs=4 ft=0", done_e, cs_b, ft_b);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        while (n < 25) begin
            tick();
            record(ro_a);
            rdy_a = resp(4'hF);
        end
        #2;
        rst   = 1'b1;
        rdy_a = 4'h0;
        #1;
        checks++;
        if ({ro_a, cs_a, dn_a} !== {4'hF, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_async: got ro=%b cs=%0d dn=%b, want ro=1111 cs=0 dn=0", ro_a, cs_a, dn_a);
        end
        clear_falls();
        @(negedge clk);
        rst = 1'b0;
        n   = 0;
        run_staged("restart");
    endtask

    // Drives instance C to the WAIT(2) timeout fault at edge 142.
    task automatic run_to_fault();
        do_reset();
        while (n < 141) begin
            tick();
            record(ro_c);
            rdy_c = resp(4'b1011);
        end
        checks++;
        if (ft_c !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: fault=%b at edge 141, want 0", ft_c);
        end
        tick();
        checks++;
        if ({ft_c, ro_c, cs_c, dn_c} !== {1'b1, 4'hF, 3'd2, 1'b0}) begin
            errors++;
            $display("FAIL timeout_hit: got ft=%b ro=%b cs=%0d dn=%b, want ft=1 ro=1111 cs=2 dn=0", ft_c, ro_c, cs_c, dn_c);
        end
    endtask

    task automatic test_timeout();
        int bad;
        bad = 0;
        run_to_fault();
        repeat (1000) begin
            tick();
            rdy_c = resp(4'b1011);
            if ({ft_c, ro_c, cs_c, dn_c} !== {1'b1, 4'hF, 3'd2, 1'b0}) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_sticky: %0d cycles left fault state, want 0", bad);
        end
    endtask

    task automatic test_rdy_wins();
        int done_e;
        done_e = -1;
        do_reset();
        while (n < 170) begin
            tick();
            record(ro_c);
            if (dn_c && done_e < 0) done_e = n;
            if (n == 142) begin
                checks++;
                if ({ft_c, cs_c, ro_c} !== {1'b0, 3'd2, 4'b1000}) begin
                    errors++;
                    $display("FAIL rdy_wins_edge: got ft=%b cs=%0d ro=%b, want ft=0 cs=2 ro=1000", ft_c, cs_c, ro_c);
                end
            end
            rdy_c = resp((n >= 141) ? 4'hF : 4'b1011);
        end
        checks++;
        if (fall_e[3] !== 150) begin
            errors++;
            $display("FAIL rdy_wins_rel3: released at edge %0d, want 150", fall_e[3]);
        end
        checks++;
        if (done_e !== 155 || ft_c !== 1'b0) begin
            errors++;
            $display("FAIL rdy_wins_done: done edge %0d ft=%b, want edge 155 ft=0", done_e, ft_c);
        end
    endtask

`ifdef RST_SEQ_SOFT_RST_EN
    task automatic test_soft_reset();
        soft_c = 1'b0;
        run_to_fault();
        soft_c = 1'b1;
        rdy_c  = 4'h0;
        clear_falls();
        tick();
        checks++;
        if ({ft_c, ro_c, cs_c, dn_c} !== {1'b0, 4'hF, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL soft_clear: got ft=%b ro=%b cs=%0d dn=%b, want ft=0 ro=1111 cs=0 dn=0", ft_c, ro_c, cs_c, dn_c);
        end
        tick();
        tick();
        soft_c = 1'b0;
        while (n < 170) begin
            tick();
            record(ro_c);
        end
        checks++;
        if (fall_e[0] !== 161) begin
            errors++;
            $display("FAIL soft_rel0: released at edge %0d, want 161", fall_e[0]);
        end
    endtask
`endif

    initial begin
        rdy_a = 4'h0;
        rdy_b = 4'hF;
        rdy_c = 4'h0;
`ifdef RST_SEQ_SOFT_RST_EN
        soft_c = 1'b0;
`endif
        clear_falls();
        repeat (2) @(posedge clk);
        test_reset();
        test_staged();
        test_gap0();
        test_rst_mid();
        test_timeout();
        test_rdy_wins();
`ifdef RST_SEQ_SOFT_RST_EN
        test_soft_reset();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
